// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one multi-cycle ALU between NUM_REQ requesters. A round-robin pick
//   grants one requester, its operands are latched and issued to the ALU for a
//   single cycle, the arbiter waits the command-dependent ALU latency, captures
//   RES and flags, and holds them for the grantee until it accepts them.
//
// Ports
//   CLK, RST, CE            clock, synchronous active-high reset, clock enable
//   req_valid/req_ready     per-requester request / one-hot accept strobe
//   req_mode/ivld/cmd/cin   per-requester ALU control fields (packed by index)
//   req_opa/req_opb         per-requester operands (packed by index)
//   rsp_valid/rsp_ready     one-hot response valid / per-requester accept
//   rsp_res, rsp_flags      captured RES and {ERR,OFLOW,COUT,G,L,E,1'b0}
//   alu_*  (out)            drive the ALU INP_VALID/MODE/CMD/CIN/OPA/OPB pins
//   alu_res, alu_err..alu_e ALU result and flags
//   busy, gnt_id            not idle / index of current grantee
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int CMD_W   = 4,
    parameter int LAT     = 1,
    parameter int LAT_MUL = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CE,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_mode,
    input  logic [2*NUM_REQ-1:0]       req_ivld,
    input  logic [CMD_W*NUM_REQ-1:0]   req_cmd,
    input  logic [NUM_REQ-1:0]         req_cin,
    input  logic [WIDTH*NUM_REQ-1:0]   req_opa,
    input  logic [WIDTH*NUM_REQ-1:0]   req_opb,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_res,
    output logic [6:0]                 rsp_flags,
    output logic [1:0]                 alu_ivld,
    output logic                       alu_mode,
    output logic [CMD_W-1:0]           alu_cmd,
    output logic                       alu_cin,
    output logic [WIDTH-1:0]           alu_opa,
    output logic [WIDTH-1:0]           alu_opb,
    input  logic [2*WIDTH-1:0]         alu_res,
    input  logic                       alu_err,
    input  logic                       alu_oflow,
    input  logic                       alu_cout,
    input  logic                       alu_g,
    input  logic                       alu_l,
    input  logic                       alu_e,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

    localparam int IDW     = $clog2(NUM_REQ);
    localparam int LAT_MAX = (LAT_MUL > LAT) ? LAT_MUL : LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [IDW-1:0]     gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // The alu_* registers double as the latched copy of the granted request.
    logic [1:0]         ivld_q, ivld_d;
    logic               mode_q, mode_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               cin_q, cin_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [6:0]         flags_q, flags_d;

    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [IDW:0]       scan_idx;
    logic               is_mul;

    // Round-robin pick: first valid requester at or above rr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[scan_idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan_idx[IDW-1:0];
            end
        end
    end

    assign is_mul = mode_q && ((cmd_q == CMD_W'(9)) || (cmd_q == CMD_W'(10)));

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // no path through the case can leave a variable unassigned (no latch).
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ivld_d  = ivld_q;
        mode_d  = mode_q;
        cmd_d   = cmd_q;
        cin_d   = cin_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        flags_d = flags_q;

        if (CE) begin
            unique case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_d   = win_id;
                        ivld_d  = req_ivld[2*win_id +: 2];
                        mode_d  = req_mode[win_id];
                        cmd_d   = req_cmd[CMD_W*win_id +: CMD_W];
                        cin_d   = req_cin[win_id];
                        opa_d   = req_opa[WIDTH*win_id +: WIDTH];
                        opb_d   = req_opb[WIDTH*win_id +: WIDTH];
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // INP_VALID is a one-cycle pulse; the other pins keep the operands.
                    ivld_d  = 2'b00;
                    cnt_d   = is_mul ? CNT_W'(LAT_MUL) : CNT_W'(LAT);
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = alu_res;
                        flags_d = {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e, 1'b0};
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        rr_d    = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before the edge, independent of statement order.
        if (RST) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ivld_q  <= '0;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            cin_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ivld_q  <= ivld_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            cin_q   <= cin_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    // Accept strobe is combinational; suppressed while frozen or in reset so
    // a requester never sees an accept that the registers do not take.
    always_comb begin
        req_ready = '0;
        if (!RST && CE && (state_q == S_IDLE) && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == S_RESP) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign rsp_res   = res_q;
    assign rsp_flags = flags_q;
    assign alu_ivld  = ivld_q;
    assign alu_mode  = mode_q;
    assign alu_cmd   = cmd_q;
    assign alu_cin   = cin_q;
    assign alu_opa   = opa_q;
    assign alu_opb   = opb_q;
    assign busy      = (state_q != S_IDLE);
    assign gnt_id    = gnt_q;

endmodule
